// File: rtl/mem_arbiter.sv
// Three-requester round-robin memory arbiter (data, fetch, dma) driving a single
// handshaked memory port, with a per-access timeout that returns 8'hFF and err.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata2,
  output logic [2:0]        ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state, state_nx;
  logic [1:0]        last_grant, grant, winner;
  logic [CNT_W-1:0]  tcnt;
  logic              timeout_hit;
  logic [7:0]        rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [7:0]        sel_wdata;

  // The counter holds (BUSY cycles - 1), so the abort fires in BUSY cycle TIMEOUT.
  assign timeout_hit = (tcnt == CNT_W'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = 2'd0;
    case (last_grant)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // The fetch port is read-only: its write enable is never honoured.
  always_comb begin
    sel_addr  = addr0;
    sel_we    = we[0];
    sel_wdata = wdata0;
    case (winner)
      2'd1: begin
        sel_addr  = addr1;
        sel_we    = 1'b0;
        sel_wdata = 8'h00;
      end
      2'd2: begin
        sel_addr  = addr2;
        sel_we    = we[2];
        sel_wdata = wdata2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = BUSY;
      BUSY:    if (mem_ready || timeout_hit) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req = (state == BUSY);
  assign ack     = (state == ACK) ? (3'b001 << grant) : 3'b000;
  assign rdata   = (state == ACK) ? rdata_q : 8'h00;
  assign err     = (state == ACK) && err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      grant      <= 2'd0;
      tcnt       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|req) begin
            grant      <= winner;
            last_grant <= winner;
            tcnt       <= '0;
            mem_addr   <= sel_addr;
            mem_we     <= sel_we;
            mem_wdata  <= sel_wdata;
          end
        end
        BUSY: begin
          tcnt <= tcnt + 1'b1;
          // A completion in the timeout cycle still returns real data.
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= 8'hFF;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
